// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide sequencer: FSM states and the
// architectural divide-by-zero quotient.
package div_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ZERO,
    LAUNCH,
    WAIT,
    FIXUP,
    DRAIN
  } div_state_e;

  localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_ctrl_abs_neg32.sv
// Conditional two's-complement negator, used both for operand magnitudes
// and for sign-correcting the divider results.
module abs_neg32 (
  input  logic [31:0] in_i,
  input  logic        neg_i,
  output logic [31:0] out_o
);

  assign out_o = neg_i ? (~in_i + 32'd1) : in_i;

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between EX and the external iterative unsigned divider: converts
// DIV/DIVU to magnitudes, runs the divider, sign-corrects and writes HI/LO.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        stall,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  div_state_e    state_q, state_d;
  logic [31:0]   a_q, b_q;
  logic          signed_q;
  logic          seen_q, seen_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;

  logic          accept;
  logic          neg_a, neg_b, sign_quo;
  logic [31:0]   mag_a, mag_b, fix_q, fix_r;
  logic          done, expired;

  // Raw operands are kept; magnitudes and signs are derived from them so the
  // zero path can still return the original dividend.
  assign neg_a    = signed_q & a_q[31];
  assign neg_b    = signed_q & b_q[31];
  assign sign_quo = neg_a ^ neg_b;

  abs_neg32 u_mag_a (.in_i(a_q),   .neg_i(neg_a),    .out_o(mag_a));
  abs_neg32 u_mag_b (.in_i(b_q),   .neg_i(neg_b),    .out_o(mag_b));
  abs_neg32 u_fix_q (.in_i(div_q), .neg_i(sign_quo), .out_o(fix_q));
  abs_neg32 u_fix_r (.in_i(div_r), .neg_i(neg_a),    .out_o(fix_r));

  assign accept      = (state_q == IDLE) && req_valid && !flush && !reset;
  assign done        = seen_q && !div_busy;
  assign expired     = timer_q >= TW'(TIMEOUT - 1);
  assign timeout_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      seen_q   <= 1'b0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      if (accept) begin
        a_q      <= req_a;
        b_q      <= req_b;
        signed_q <= req_signed;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    seen_d       = seen_q;
    timer_d      = timer_q;
    err_d        = err_q;
    req_ready    = 1'b0;
    stall        = 1'b0;
    hilo_we      = 1'b0;
    hi_o         = '0;
    lo_o         = '0;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          req_ready = 1'b1;
          seen_d    = 1'b0;
          timer_d   = '0;
          if (req_valid && !flush) begin
            stall   = 1'b1;
            err_d   = 1'b0;
            state_d = (req_b == '0) ? ZERO : LAUNCH;
          end
        end
        ZERO: begin
          hilo_we = !flush;
          hi_o    = a_q;
          lo_o    = DIV_BY_ZERO_LO;
          state_d = IDLE;
        end
        LAUNCH: begin
          // The divider may still be finishing work begun before a reset.
          stall        = 1'b1;
          div_dividend = mag_a;
          div_divisor  = mag_b;
          div_start    = !div_busy;
          seen_d       = 1'b0;
          timer_d      = '0;
          if (flush)          state_d = DRAIN;
          else if (!div_busy) state_d = WAIT;
        end
        WAIT: begin
          stall        = 1'b1;
          div_dividend = mag_a;
          div_divisor  = mag_b;
          seen_d       = seen_q | div_busy;
          timer_d      = timer_q + TW'(1);
          if (flush) begin
            state_d = done ? IDLE : DRAIN;
          end else if (done) begin
            state_d = FIXUP;
          end else if (expired) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        DRAIN: begin
          // Timer keeps running so a hung divider cannot trap the drain.
          div_dividend = mag_a;
          div_divisor  = mag_b;
          seen_d       = seen_q | div_busy;
          timer_d      = expired ? timer_q : timer_q + TW'(1);
          if (done) begin
            state_d = IDLE;
          end else if (expired) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        FIXUP: begin
          hilo_we = !flush;
          hi_o    = fix_r;
          lo_o    = fix_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a cycle-level divider stand-in and an
// arithmetic reference for DIV/DIVU results.
module tb_div_ctrl;

  localparam int unsigned TIMEOUT = 40;
  localparam int unsigned DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_signed = 1'b0, flush = 1'b0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready, stall, hilo_we, div_start, timeout_err;
  logic [31:0] hi_o, lo_o, div_dividend, div_divisor;
  logic        div_busy;
  logic [31:0] div_q = '0, div_r = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_signed(req_signed), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .flush(flush), .stall(stall),
    .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_q(div_q), .div_r(div_r),
    .timeout_err(timeout_err)
  );

  // Divider stand-in: busy for DIV_LAT cycles after a start, unaffected by reset.
  logic        dv_busy = 1'b0;
  logic        dv_stuck = 1'b0;
  int          dv_cnt = 0;
  int          n_starts = 0;
  int          bad_starts = 0;
  logic [31:0] last_dividend = '0, last_divisor = '0;
  logic [31:0] pend_q = '0, pend_r = '0;

  assign div_busy = dv_busy;

  always @(posedge clk) begin
    if (div_start) begin
      n_starts <= n_starts + 1;
      if (dv_busy) begin
        bad_starts <= bad_starts + 1;
      end else begin
        last_dividend <= div_dividend;
        last_divisor  <= div_divisor;
        pend_q  <= (div_divisor != 0) ? div_dividend / div_divisor : 32'hFFFF_FFFF;
        pend_r  <= (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
        div_q   <= 32'hDEAD_BEEF;
        div_r   <= 32'hDEAD_BEEF;
        dv_busy <= 1'b1;
        dv_cnt  <= DIV_LAT;
      end
    end else if (dv_busy) begin
      if (dv_cnt > 1) begin
        dv_cnt <= dv_cnt - 1;
      end else if (!dv_stuck) begin
        dv_busy <= 1'b0;
        div_q   <= pend_q;
        div_r   <= pend_r;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb;
    if (b == 0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lo = 32'(sa / sb);
      hi = 32'(sa % sb);
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  function automatic logic [31:0] mag(input logic sg, input logic [31:0] v);
    return (sg && v[31]) ? 32'd0 - v : v;
  endfunction

  // Issues one request and follows it to its HI/LO write (bounded).
  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, output logic [31:0] hi, output logic [31:0] lo,
                        output int start_lat);
    int lat;
    int starts0;
    bit got;
    bit stall_bad;
    starts0 = n_starts;
    @(negedge clk);
    req_valid = 1'b1; req_signed = sg; req_a = a; req_b = b;
    #1;
    check("accept_ready", req_ready, 1);
    check("accept_stall", stall, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_signed = $urandom_range(0, 1);
    lat = 0; got = 0; stall_bad = 0; start_lat = -1; hi = '0; lo = '0;
    while (lat < 300 && !got) begin
      if (div_start && start_lat < 0) start_lat = lat;
      if (hilo_we) begin
        got = 1; hi = hi_o; lo = lo_o;
        if (stall) stall_bad = 1;
      end else begin
        if (!stall) stall_bad = 1;
        @(posedge clk); #1;
        lat++;
      end
    end
    check("write_seen", 32'(got), 1);
    check("stall_shape", 32'(stall_bad), 0);
    @(posedge clk); #1;
    check("single_we", hilo_we, 0);
    if (b == 0) begin
      check("zero_lat", lat, 0);
      check("zero_no_start", n_starts - starts0, 0);
    end else begin
      check("one_start", n_starts - starts0, 1);
      check("dividend_mag", last_dividend, mag(sg, a));
      check("divisor_mag", last_divisor, mag(sg, b));
      if (exp_lat >= 0) begin
        check("start_lat", start_lat, 0);
        check("write_lat", lat, exp_lat);
      end
    end
  endtask

  typedef struct {
    logic        sg;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[10];
    logic [31:0] hi, lo, ehi, elo, a, b;
    logic        sg;
    int          sl, starts0, bad0;
    bit          we_bad;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14};
    vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFF2};
    vecs[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFF2};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[4] = '{1'b0, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF};
    vecs[5] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  32'hFFFF_FFFF};
    vecs[6] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd14};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF};
    vecs[8] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[9] = '{1'b1, 32'd3,          32'd10,         32'd3,          32'd0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_stall", stall, 0);
    check("rst_we", hilo_we, 0);
    check("rst_start", div_start, 0);
    check("rst_err", timeout_err, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", req_ready, 1);

    foreach (vecs[i]) begin
      run_op(vecs[i].sg, vecs[i].a, vecs[i].b, DIV_LAT + 2, hi, lo, sl);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end

    // flush while idle must not accept
    starts0 = n_starts;
    @(negedge clk);
    req_valid = 1'b1; req_b = 32'd3; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("idle_flush_ready", req_ready, 1);
    check("idle_flush_nostart", n_starts - starts0, 0);

    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = $urandom_range(1, 16);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: ;
      endcase
      ref_div(sg, a, b, ehi, elo);
      run_op(sg, a, b, DIV_LAT + 2, hi, lo, sl);
      check("rnd_hi", hi, ehi);
      check("rnd_lo", lo, elo);
    end

    // Flush ten cycles into WAIT, then drain
    @(negedge clk);
    req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd1000; req_b = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("wait_stall", stall, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("drain_stall", stall, 0);
    check("drain_ready", req_ready, 0);
    we_bad = 0;
    for (int i = 0; i < 100 && !req_ready; i++) begin
      if (hilo_we) we_bad = 1;
      @(posedge clk); #1;
    end
    check("drain_exit", req_ready, 1);
    check("drain_busy_done", div_busy, 0);
    check("drain_no_we", 32'(we_bad), 0);
    run_op(1'b0, 32'd1000, 32'd3, DIV_LAT + 2, hi, lo, sl);
    check("post_flush_hi", hi, 32'd1);
    check("post_flush_lo", lo, 32'd333);

    // Reset in the middle of WAIT while the divider is busy
    @(negedge clk);
    req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd2000; req_b = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_stall", stall, 0);
    check("midrst_we", hilo_we, 0);
    check("midrst_start", div_start, 0);
    check("midrst_err", timeout_err, 0);
    reset = 1'b0;
    bad0 = bad_starts;
    ref_div(1'b1, 32'hFFFF_F830, 32'd7, ehi, elo);
    run_op(1'b1, 32'hFFFF_F830, 32'd7, -1, hi, lo, sl);
    check("postrst_hi", hi, ehi);
    check("postrst_lo", lo, elo);
    check("postrst_no_start_busy", bad_starts - bad0, 0);
    check("postrst_start_waited", 32'(sl > 0), 1);

    // Divider that never finishes
    dv_stuck = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd50; req_b = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("tmo_start", div_start, 1);
    we_bad = 0;
    for (int i = 1; i <= int'(TIMEOUT); i++) begin
      @(posedge clk); #1;
      if (hilo_we) we_bad = 1;
    end
    check("tmo_pending_err", timeout_err, 0);
    check("tmo_pending_stall", stall, 1);
    @(posedge clk); #1;
    check("tmo_err", timeout_err, 1);
    check("tmo_idle", req_ready, 1);
    check("tmo_stall", stall, 0);
    check("tmo_no_we", 32'(we_bad | hilo_we), 0);
    dv_stuck = 1'b0;
    @(posedge clk); #1;
    check("tmo_sticky", timeout_err, 1);
    run_op(1'b0, 32'd50, 32'd5, DIV_LAT + 2, hi, lo, sl);
    check("tmo_next_lo", lo, 32'd10);
    check("tmo_next_hi", hi, 32'd0);
    check("tmo_cleared", timeout_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
